// File: rtl/ws2812b_rx_decoder.sv
// ws2812b_rx_decoder
//   Receive side of the WS2812B single-wire LED protocol. Each high pulse on
//   din is timed and classified as a 0 or 1 bit. Bits are assembled MSB-first
//   into 24-bit GRB words, which are handed out over a valid/ready handshake.
//   A long low gap closes a frame.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   din           serial line, asynchronous to clk
//   pixel         decoded {G,R,B} word, first-received bit in [23]
//   pixel_valid   pixel/pixel_idx hold an unconsumed word
//   pixel_ready   consumer accepts when valid && ready
//   pixel_idx     word position within the current frame
//   frame_end     1-cycle pulse when a gap closes a frame
//   err_overflow  sticky: a word completed while the previous was still held
//   err_pulse     sticky: over-long pulse, or frame ended mid-word
//   err_clear     clears both sticky flags (a same-cycle set wins)
module ws2812b_rx_decoder #(
  parameter int BIT_THRESH = 38,
  parameter int MIN_HIGH   = 8,
  parameter int MAX_HIGH   = 96,
  parameter int RESET_LOW  = 3200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic [5:0]  pixel_idx,
  output logic        frame_end,
  output logic        err_overflow,
  output logic        err_pulse,
  input  logic        err_clear
);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_LOW + 1);

  typedef enum logic [1:0] {ALIGN, IDLE, HIGH} state_t;

  state_t        state;
  logic          s1, ds, ds_q;
  logic [HW-1:0] high_cnt;
  logic [LW-1:0] low_cnt;
  logic [23:0]   shift;
  logic [4:0]    bit_cnt;
  logic [5:0]    word_cnt;
  logic          frame_active;  // a bit was accepted since the last frame end

  logic rise, fall, low_hit, bit_val, accept;
  logic [23:0] shift_nxt;

  assign rise      = ds & ~ds_q;
  assign fall      = ~ds & ds_q;
  // True only on the single cycle low_cnt steps onto RESET_LOW.
  assign low_hit   = ~ds && (low_cnt == LW'(RESET_LOW - 1));
  assign bit_val   = high_cnt >= HW'(BIT_THRESH);
  assign accept    = pixel_valid & pixel_ready;
  assign shift_nxt = {shift[22:0], bit_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      ds       <= 1'b0;
      ds_q     <= 1'b0;
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      s1   <= din;
      ds   <= s1;
      ds_q <= ds;
      if (ds) begin
        low_cnt <= '0;
        if (high_cnt != HW'(MAX_HIGH + 1)) high_cnt <= high_cnt + 1'b1;
      end else begin
        high_cnt <= '0;
        if (low_cnt != LW'(RESET_LOW)) low_cnt <= low_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ALIGN;
      shift        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      frame_active <= 1'b0;
      pixel        <= '0;
      pixel_idx    <= '0;
      pixel_valid  <= 1'b0;
      frame_end    <= 1'b0;
      err_overflow <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      if (accept) pixel_valid <= 1'b0;
      // Clear first so that any set below overrides it.
      if (err_clear) begin
        err_overflow <= 1'b0;
        err_pulse    <= 1'b0;
      end
      case (state)
        ALIGN: if (low_hit) state <= IDLE;
        IDLE: begin
          if (rise) begin
            state <= HIGH;
          end else if (low_hit && frame_active) begin
            frame_end    <= 1'b1;
            word_cnt     <= '0;
            frame_active <= 1'b0;
            if (bit_cnt != 5'd0) begin
              err_pulse <= 1'b1;
              bit_cnt   <= '0;
            end
          end
        end
        HIGH: begin
          if (fall) begin
            if (high_cnt < HW'(MIN_HIGH)) begin
              state <= IDLE;
            end else if (high_cnt > HW'(MAX_HIGH)) begin
              err_pulse <= 1'b1;
              bit_cnt   <= '0;
              state     <= ALIGN;
            end else begin
              state        <= IDLE;
              frame_active <= 1'b1;
              shift        <= shift_nxt;
              // The 24th bit completes the word on the same edge it is
              // shifted, so valid rises 3 clk after the din fall.
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                word_cnt <= word_cnt + 1'b1;
                if (!pixel_valid || accept) begin
                  pixel       <= shift_nxt;
                  pixel_idx   <= word_cnt;
                  pixel_valid <= 1'b1;
                end else begin
                  err_overflow <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= ALIGN;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
module tb_ws2812b_rx_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        pixel_ready = 1'b0;
  logic        err_clear = 1'b0;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [5:0]  pixel_idx;
  logic        frame_end;
  logic        err_overflow;
  logic        err_pulse;

  int n_cmp = 0;
  int n_err = 0;

  ws2812b_rx_decoder dut (
    .clk(clk), .rst_n(rst_n), .din(din),
    .pixel(pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_idx(pixel_idx), .frame_end(frame_end),
    .err_overflow(err_overflow), .err_pulse(err_pulse), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // Log of accepted words and count of frame_end pulses.
  logic [23:0] cap_pix [0:63];
  logic [5:0]  cap_idx [0:63];
  int cap_n = 0;
  int fe_total = 0;
  always @(posedge clk) begin
    if (rst_n && pixel_valid && pixel_ready && cap_n < 64) begin
      cap_pix[cap_n] <= pixel;
      cap_idx[cap_n] <= pixel_idx;
      cap_n <= cap_n + 1;
    end
    if (rst_n && frame_end) fe_total <= fe_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input int h, input int l);
    @(negedge clk) din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      if (w[23 - i]) pulse(51, 29);
      else           pulse(26, 54);
    end
  endtask

  task automatic gap();
    @(negedge clk) din = 1'b0;
    repeat (3300) @(negedge clk);
  endtask

  task automatic ready_pulse();
    @(negedge clk) pixel_ready = 1'b1;
    @(negedge clk) pixel_ready = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk) err_clear = 1'b1;
    @(negedge clk) err_clear = 1'b0;
  endtask

  int fe0, c0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pixel", 32'(pixel), 32'h0);
    chk("rst_valid", 32'(pixel_valid), 32'h0);
    chk("rst_idx", 32'(pixel_idx), 32'h0);
    chk("rst_flags", {29'h0, frame_end, err_overflow, err_pulse}, 32'h0);
    rst_n = 1'b1;

    // 1: align gap, then 0xFF0055; check 3-clk valid latency
    gap();
    chk("t1_no_fe_on_align", 32'(fe_total), 32'd0);
    send_bits(24'hFF0055, 23);
    @(negedge clk) din = 1'b1;
    repeat (51) @(negedge clk);
    din = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("t1_valid_2clk", 32'(pixel_valid), 32'h0);
    @(posedge clk); #1;
    chk("t1_valid_3clk", 32'(pixel_valid), 32'h1);
    chk("t1_pixel", 32'(pixel), 32'hFF0055);
    chk("t1_idx", 32'(pixel_idx), 32'h0);
    chk("t1_errs", {30'h0, err_overflow, err_pulse}, 32'h0);
    repeat (26) @(negedge clk);
    ready_pulse();
    @(negedge clk);
    chk("t1_valid_drop", 32'(pixel_valid), 32'h0);
    fe0 = fe_total;
    gap();
    chk("t1_fe", 32'(fe_total - fe0), 32'd1);

    // 2: three words with ready=1, then gap
    pixel_ready = 1'b1;
    c0 = cap_n;
    fe0 = fe_total;
    send_bits(24'h123456, 24);
    send_bits(24'hABCDEF, 24);
    send_bits(24'h000001, 24);
    chk("t2_cnt", 32'(cap_n - c0), 32'd3);
    chk("t2_p0", 32'(cap_pix[c0]), 32'h123456);
    chk("t2_i0", 32'(cap_idx[c0]), 32'd0);
    chk("t2_p1", 32'(cap_pix[c0 + 1]), 32'hABCDEF);
    chk("t2_i1", 32'(cap_idx[c0 + 1]), 32'd1);
    chk("t2_p2", 32'(cap_pix[c0 + 2]), 32'h000001);
    chk("t2_i2", 32'(cap_idx[c0 + 2]), 32'd2);
    chk("t2_fe_none_yet", 32'(fe_total - fe0), 32'd0);
    gap();
    chk("t2_fe", 32'(fe_total - fe0), 32'd1);
    c0 = cap_n;
    send_bits(24'h00FF00, 24);
    chk("t2_next_p", 32'(cap_pix[c0]), 32'h00FF00);
    chk("t2_next_idx", 32'(cap_idx[c0]), 32'd0);
    gap();

    // 3: overflow with ready=0
    pixel_ready = 1'b0;
    send_bits(24'h0F0F0F, 24);
    chk("t3_valid", 32'(pixel_valid), 32'h1);
    chk("t3_no_ovf_yet", 32'(err_overflow), 32'h0);
    send_bits(24'hF0F0F0, 24);
    chk("t3_ovf", 32'(err_overflow), 32'h1);
    chk("t3_hold_pix", 32'(pixel), 32'h0F0F0F);
    chk("t3_hold_idx", 32'(pixel_idx), 32'd0);
    chk("t3_no_perr", 32'(err_pulse), 32'h0);
    clear_pulse();
    chk("t3_ovf_clr", 32'(err_overflow), 32'h0);
    chk("t3_still_valid", 32'(pixel_valid), 32'h1);
    ready_pulse();
    @(negedge clk);
    chk("t3_drained", 32'(pixel_valid), 32'h0);
    gap();

    // 4: glitches between bits
    pixel_ready = 1'b1;
    c0 = cap_n;
    begin
      logic [23:0] w4;
      w4 = 24'hA5C33C;
      for (int i = 0; i < 24; i++) begin
        if (w4[23 - i]) pulse(51, 29);
        else            pulse(26, 54);
        pulse(4, 30);
      end
    end
    chk("t4_cnt", 32'(cap_n - c0), 32'd1);
    chk("t4_pix", 32'(cap_pix[c0]), 32'hA5C33C);
    chk("t4_idx", 32'(cap_idx[c0]), 32'd0);
    chk("t4_errs", {30'h0, err_overflow, err_pulse}, 32'h0);
    gap();

    // 5: partial word then gap
    c0 = cap_n;
    fe0 = fe_total;
    send_bits(24'hFFF000, 12);
    gap();
    chk("t5_no_word", 32'(cap_n - c0), 32'd0);
    chk("t5_valid", 32'(pixel_valid), 32'h0);
    chk("t5_perr", 32'(err_pulse), 32'h1);
    chk("t5_fe", 32'(fe_total - fe0), 32'd1);
    clear_pulse();
    chk("t5_perr_clr", 32'(err_pulse), 32'h0);
    send_bits(24'h5A5A5A, 24);
    chk("t5_pix", 32'(cap_pix[c0]), 32'h5A5A5A);
    chk("t5_idx", 32'(cap_idx[c0]), 32'd0);
    gap();

    // 6: over-long pulse, recovery only after a gap, then async reset
    pulse(150, 30);
    chk("t6_perr", 32'(err_pulse), 32'h1);
    c0 = cap_n;
    fe0 = fe_total;
    send_bits(24'h111111, 24);
    chk("t6_ignored", 32'(cap_n - c0), 32'd0);
    chk("t6_ign_valid", 32'(pixel_valid), 32'h0);
    gap();
    chk("t6_no_fe", 32'(fe_total - fe0), 32'd0);
    send_bits(24'h222222, 24);
    chk("t6_recov_cnt", 32'(cap_n - c0), 32'd1);
    chk("t6_recov_pix", 32'(cap_pix[c0]), 32'h222222);
    send_bits(24'hFFC000, 10);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("t6_rst_pixel", 32'(pixel), 32'h0);
    chk("t6_rst_idx", 32'(pixel_idx), 32'h0);
    chk("t6_rst_flags", {28'h0, pixel_valid, frame_end, err_overflow, err_pulse}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_post_rst", {28'h0, pixel_valid, frame_end, err_overflow, err_pulse}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
